or1200_lite_top: RTL and testbench
==================================

// Module: or1200_lite_top
// PURPOSE
//  Reduced OpenRISC 1000 (ORBIS32 subset) CPU with the or1200_top pin-out; drops into the same wrapper/testbench sockets.
//  Multicycle, non-pipelined core: separate Wishbone instruction and data masters; debug, PIC and PM pins stubbed.
//  Big-endian, 32 GPRs, architectural branch delay slot. Runs with a zero-wait-state memory model (ack same cycle as stb).
// PARAMETERS
//  RESET_PC  32'h0000_0100  address of first instruction fetch after reset
// PORTS
//  clk_i  in  1  sole clock; iwb_clk_i/dwb_clk_i  in 1  must be tied to clk_i, ignored
//  rst_i  in  1  synchronous active-high reset; iwb_rst_i/dwb_rst_i  in 1  ignored
//  pic_ints_i in 20, clmode_i in 2  ignored
//  iwb_cyc_o/iwb_stb_o out 1 fetch request; iwb_adr_o out 32 fetch PC; iwb_dat_i in 32 instruction
//  iwb_ack_i/iwb_err_i/iwb_rty_i in 1  cycle termination; iwb_we_o=0, iwb_sel_o=4'hF, iwb_dat_o=0, iwb_cti_o=0, iwb_bte_o=0 out
//  dwb_cyc_o/dwb_stb_o/dwb_we_o out 1; dwb_adr_o out 32; dwb_sel_o out 4; dwb_dat_o out 32; dwb_dat_i in 32
//  dwb_ack_i/dwb_err_i/dwb_rty_i in 1; dwb_cti_o out 3 =0; dwb_bte_o out 2 =0
//  dbg_stall_i, dbg_ewt_i, dbg_stb_i, dbg_we_i in 1; dbg_adr_i, dbg_dat_i in 32
//  dbg_lss_o 4, dbg_is_o 2, dbg_wp_o 11, dbg_bp_o 1, dbg_dat_o 32  out, constant 0; dbg_ack_o out 1 = dbg_stb_i
//  pm_cpustall_i in 1 stall request; pm_clksd_o out 4 =0; pm_*_gate_o, pm_wakeup_o, pm_lvolt_o, sig_tick out 1 =0
// BEHAVIOUR
//  States: FETCH -> EXEC -> (MEM for load/store) -> FETCH. Reset: state=FETCH, PC=RESET_PC, SR.F=0, no pending branch, all bus outputs 0.
//  GPRs not reset; r0 always reads 0 and writes to it are dropped.
//  FETCH: if dbg_stall_i|pm_cpustall_i, cyc/stb stay 0 and state holds; else cyc=stb=1, adr=PC, held until ack|err.
//   ack: latch insn; err: latch l.nop (0x15000000); rty: keep request. Zero-wait memory -> 2 clk/insn, 3 clk/load-store.
//  EXEC: decode [31:26]; rD=[25:21], rA=[20:16], rB=[15:11], imm16=[15:0]; writeback on the EXEC clock edge.
//   0x27 l.addi, 0x2B l.xori: sign-extended imm; 0x29 l.andi, 0x2A l.ori: zero-extended; 0x06 l.movhi: rD={imm16,16'h0}.
//   0x38 ALU by [3:0]: 0 add, 2 sub, 3 and, 4 or, 5 xor, 8 shift ([7:6] 0 sll, 1 srl, 2 sra, rB[4:0]).
//   0x2E shift-imm: [7:6] type, [4:0] amount. Add/sub wrap mod 2^32; no carry/overflow flags.
//   0x39 l.sf / 0x2F l.sfi (sign-ext imm), cond [25:21]: 0 eq, 1 ne, 2 gtu, 3 geu, 4 ltu, 5 leu, A gts, B ges, C lts, D les -> SR.F.
//   0x00 l.j, 0x01 l.jal, 0x04 l.bf (F=1), 0x03 l.bnf (F=0): target = PC + sext({[25:0],2'b00}).
//   0x11 l.jr / 0x12 l.jalr: target = rB. jal/jalr write r9 = PC+8.
//   Taken branch: next PC=PC+4 (delay slot runs), then PC=target. Branch inside a delay slot executes as l.nop.
//   0x05 l.nop and all unlisted opcodes: no state change except PC advance.
//  MEM: eff addr = rA + sext(imm); loads imm16, stores imm={[25:21],[10:0]} with data reg rB.
//   dwb_cyc/stb held until ack|err. Word accesses force adr[1:0]=0; halfword forces adr[0]=0; dwb_adr_o = resulting address.
//   Loads 0x21 lwz, 0x23 lbz, 0x24 lbs, 0x25 lhz, 0x26 lhs; big-endian lane select; write rD on ack; err -> rD=0.
//   Stores 0x35 sw sel=F, 0x37 sh sel=C/3 (adr[1]=0/1), 0x36 sb sel=8,4,2,1 (adr[1:0]=0..3); data replicated on all lanes; we=1.
//  Reset asserted mid-bus-cycle: cyc/stb/we drop on the next edge; in-flight instruction discarded, no writeback.
// TESTING
//  1 Reset 2 clk, release -> first iwb_cyc/stb with iwb_adr_o=0x100; all-NOP memory -> adr 0x104, 0x108 every 2 clk.
//  2 l.movhi r1,0; l.ori r1,r1,0x8000; l.addi r2,r0,0x1234; l.sw 0(r1),r2 -> dwb write adr=0x8000 dat=0x00001234 sel=F.
//  3 Mem[0x8000]=0x80FF0000; l.lbs r3,0(r1); l.lhz r4,0(r1); store both -> r3=0xFFFFFF80, r4=0x000080FF.
//  4 l.sb 3(r1) with r2=0xAB -> sel=1, adr=0x8003, dat[7:0]=0xAB; l.sh 2(r1) -> sel=3.
//  5 l.sfeq r0,r0; l.bf +3; l.addi r5,r0,1 (slot); skipped l.addi r5,r0,2 -> slot executes, skipped insn not fetched, r5=1.
//  6 pm_cpustall_i=1 for 10 clk during run -> no new iwb_stb_o; resume -> fetch continues at the next PC, no lost instruction.

Source files
------------

// File: rtl/or1200_lite_top.sv
// rtl/or1200_lite_top.sv - reduced multicycle ORBIS32 core with the or1200_top pin-out
//
// Purpose: FETCH -> EXEC -> (MEM) -> FETCH non-pipelined CPU with an architectural
//          branch delay slot. It has separate Wishbone instruction and data masters.
//          The debug, PIC and power-management pins are stubbed.
// Ports:   clk_i/rst_i           sole clock, synchronous active-high reset
//          iwb_*                 instruction fetch master (read only)
//          dwb_*                 data master (loads/stores, big-endian lanes)
//          dbg_*, pm_*, pic_*    stubs; dbg_stall_i/pm_cpustall_i hold off fetches
module or1200_lite_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iwb_clk_i,
    input  logic        iwb_rst_i,
    input  logic        dwb_clk_i,
    input  logic        dwb_rst_i,
    input  logic [1:0]  clmode_i,
    input  logic [19:0] pic_ints_i,
    output logic        iwb_cyc_o,
    output logic        iwb_stb_o,
    output logic        iwb_we_o,
    output logic [3:0]  iwb_sel_o,
    output logic [31:0] iwb_adr_o,
    output logic [31:0] iwb_dat_o,
    output logic [2:0]  iwb_cti_o,
    output logic [1:0]  iwb_bte_o,
    input  logic [31:0] iwb_dat_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    input  logic        iwb_rty_i,
    output logic        dwb_cyc_o,
    output logic        dwb_stb_o,
    output logic        dwb_we_o,
    output logic [3:0]  dwb_sel_o,
    output logic [31:0] dwb_adr_o,
    output logic [31:0] dwb_dat_o,
    output logic [2:0]  dwb_cti_o,
    output logic [1:0]  dwb_bte_o,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_ack_i,
    input  logic        dwb_err_i,
    input  logic        dwb_rty_i,
    input  logic        dbg_stall_i,
    input  logic        dbg_ewt_i,
    input  logic        dbg_stb_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_adr_i,
    input  logic [31:0] dbg_dat_i,
    output logic [3:0]  dbg_lss_o,
    output logic [1:0]  dbg_is_o,
    output logic [10:0] dbg_wp_o,
    output logic        dbg_bp_o,
    output logic [31:0] dbg_dat_o,
    output logic        dbg_ack_o,
    input  logic        pm_cpustall_i,
    output logic [3:0]  pm_clksd_o,
    output logic        pm_dc_gate_o,
    output logic        pm_ic_gate_o,
    output logic        pm_dmmu_gate_o,
    output logic        pm_immu_gate_o,
    output logic        pm_tt_gate_o,
    output logic        pm_cpu_gate_o,
    output logic        pm_wakeup_o,
    output logic        pm_lvolt_o,
    output logic        sig_tick
);
    localparam logic [31:0] NOP_INSN = 32'h1500_0000;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0] r_pc, r_insn, r_target, r_ea, r_wdata;
    logic [31:0] r_gpr [32];
    logic        r_flag, r_in_slot, r_we;
    logic [3:0]  r_sel;
    logic [5:0]  r_ld_op;
    logic [4:0]  r_ld_rd;

    logic [5:0]  w_op;
    logic [4:0]  w_rd, w_ra_i, w_rb_i;
    logic [15:0] w_imm;
    logic [31:0] w_ra, w_rb, w_simm, w_zimm, w_sst_imm, w_boff, w_cmp_b;
    logic        w_stall, w_iwb_req, w_dwb_req;
    logic        w_unused;

    assign w_op      = r_insn[31:26];
    assign w_rd      = r_insn[25:21];
    assign w_ra_i    = r_insn[20:16];
    assign w_rb_i    = r_insn[15:11];
    assign w_imm     = r_insn[15:0];
    assign w_ra      = (w_ra_i == 5'd0) ? 32'h0 : r_gpr[w_ra_i];
    assign w_rb      = (w_rb_i == 5'd0) ? 32'h0 : r_gpr[w_rb_i];
    assign w_simm    = {{16{w_imm[15]}}, w_imm};
    assign w_zimm    = {16'h0, w_imm};
    assign w_sst_imm = {{16{r_insn[25]}}, r_insn[25:21], r_insn[10:0]};
    assign w_boff    = {{4{r_insn[25]}}, r_insn[25:0], 2'b00};
    assign w_cmp_b   = (w_op == 6'h39) ? w_rb : w_simm;
    assign w_stall   = dbg_stall_i | pm_cpustall_i;

    function automatic logic [31:0] f_shift(input logic [31:0] a, input logic [1:0] t,
                                            input logic [4:0] s);
        case (t)
            2'd0:    f_shift = a << s;
            2'd1:    f_shift = a >> s;
            2'd2:    f_shift = $signed(a) >>> s;
            default: f_shift = a;
        endcase
    endfunction

    // ---------------- EXEC decode ----------------
    logic        w_wr_en, w_flag_en, w_flag_val, w_taken, w_is_br, w_is_mem, w_mem_we;
    logic [4:0]  w_wr_rd;
    logic [31:0] w_wr_val, w_br_tgt, w_ea, w_ea_al, w_mem_wdata;
    logic [3:0]  w_mem_sel;

    always_comb begin
        w_wr_en = 1'b0; w_wr_rd = w_rd; w_wr_val = 32'h0;
        w_flag_en = 1'b0; w_flag_val = 1'b0;
        w_is_br = 1'b0; w_taken = 1'b0; w_br_tgt = r_pc + w_boff;
        w_is_mem = 1'b0; w_mem_we = 1'b0; w_mem_sel = 4'hF; w_mem_wdata = w_rb;
        w_ea = w_ra + w_simm; w_ea_al = w_ea;
        case (w_op)
            6'h27: begin w_wr_en = 1'b1; w_wr_val = w_ra + w_simm; end
            6'h2B: begin w_wr_en = 1'b1; w_wr_val = w_ra ^ w_simm; end
            6'h29: begin w_wr_en = 1'b1; w_wr_val = w_ra & w_zimm; end
            6'h2A: begin w_wr_en = 1'b1; w_wr_val = w_ra | w_zimm; end
            6'h06: begin w_wr_en = 1'b1; w_wr_val = {w_imm, 16'h0}; end
            6'h2E: begin w_wr_en = 1'b1; w_wr_val = f_shift(w_ra, r_insn[7:6], r_insn[4:0]); end
            6'h38: begin
                w_wr_en = 1'b1;
                case (r_insn[3:0])
                    4'h0:    w_wr_val = w_ra + w_rb;
                    4'h2:    w_wr_val = w_ra - w_rb;
                    4'h3:    w_wr_val = w_ra & w_rb;
                    4'h4:    w_wr_val = w_ra | w_rb;
                    4'h5:    w_wr_val = w_ra ^ w_rb;
                    4'h8:    w_wr_val = f_shift(w_ra, r_insn[7:6], w_rb[4:0]);
                    default: w_wr_en = 1'b0;
                endcase
            end
            6'h39, 6'h2F: begin
                w_flag_en = 1'b1;
                case (w_rd)
                    5'h00:   w_flag_val = (w_ra == w_cmp_b);
                    5'h01:   w_flag_val = (w_ra != w_cmp_b);
                    5'h02:   w_flag_val = (w_ra >  w_cmp_b);
                    5'h03:   w_flag_val = (w_ra >= w_cmp_b);
                    5'h04:   w_flag_val = (w_ra <  w_cmp_b);
                    5'h05:   w_flag_val = (w_ra <= w_cmp_b);
                    5'h0A:   w_flag_val = ($signed(w_ra) >  $signed(w_cmp_b));
                    5'h0B:   w_flag_val = ($signed(w_ra) >= $signed(w_cmp_b));
                    5'h0C:   w_flag_val = ($signed(w_ra) <  $signed(w_cmp_b));
                    5'h0D:   w_flag_val = ($signed(w_ra) <= $signed(w_cmp_b));
                    default: w_flag_en  = 1'b0;
                endcase
            end
            6'h00: begin w_is_br = 1'b1; w_taken = 1'b1; end
            6'h01: begin w_is_br = 1'b1; w_taken = 1'b1;
                         w_wr_en = 1'b1; w_wr_rd = 5'd9; w_wr_val = r_pc + 32'd8; end
            6'h04: begin w_is_br = 1'b1; w_taken = r_flag; end
            6'h03: begin w_is_br = 1'b1; w_taken = ~r_flag; end
            6'h11: begin w_is_br = 1'b1; w_taken = 1'b1; w_br_tgt = w_rb; end
            6'h12: begin w_is_br = 1'b1; w_taken = 1'b1; w_br_tgt = w_rb;
                         w_wr_en = 1'b1; w_wr_rd = 5'd9; w_wr_val = r_pc + 32'd8; end
            6'h21: begin w_is_mem = 1'b1; w_ea_al = {w_ea[31:2], 2'b00}; end
            6'h23, 6'h24: begin w_is_mem = 1'b1; w_mem_sel = 4'b1000 >> w_ea[1:0]; end
            6'h25, 6'h26: begin w_is_mem = 1'b1; w_ea_al = {w_ea[31:1], 1'b0};
                                w_mem_sel = w_ea[1] ? 4'h3 : 4'hC; end
            6'h35: begin w_is_mem = 1'b1; w_mem_we = 1'b1; w_ea = w_ra + w_sst_imm;
                         w_ea_al = {w_ea[31:2], 2'b00}; end
            6'h37: begin w_is_mem = 1'b1; w_mem_we = 1'b1; w_ea = w_ra + w_sst_imm;
                         w_ea_al = {w_ea[31:1], 1'b0}; w_mem_sel = w_ea[1] ? 4'h3 : 4'hC;
                         w_mem_wdata = {2{w_rb[15:0]}}; end
            6'h36: begin w_is_mem = 1'b1; w_mem_we = 1'b1; w_ea = w_ra + w_sst_imm;
                         w_ea_al = w_ea; w_mem_sel = 4'b1000 >> w_ea[1:0];
                         w_mem_wdata = {4{w_rb[7:0]}}; end
            default: ;
        endcase
        // A branch sitting in a delay slot behaves as l.nop (no redirect, no link).
        if (w_is_br && r_in_slot) begin
            w_taken = 1'b0;
            w_wr_en = 1'b0;
        end
    end

    // ---------------- load lane extraction (big-endian) ----------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_val;
    always_comb begin
        case (r_ea[1:0])
            2'd0:    w_byte = dwb_dat_i[31:24];
            2'd1:    w_byte = dwb_dat_i[23:16];
            2'd2:    w_byte = dwb_dat_i[15:8];
            default: w_byte = dwb_dat_i[7:0];
        endcase
        w_half = r_ea[1] ? dwb_dat_i[15:0] : dwb_dat_i[31:16];
        case (r_ld_op)
            6'h23:   w_ld_val = {24'h0, w_byte};
            6'h24:   w_ld_val = {{24{w_byte[7]}}, w_byte};
            6'h25:   w_ld_val = {16'h0, w_half};
            6'h26:   w_ld_val = {{16{w_half[15]}}, w_half};
            default: w_ld_val = dwb_dat_i;
        endcase
    end

    // ---------------- state machine / bus requests ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_iwb_req   = 1'b0;
        w_dwb_req   = 1'b0;
        case (r_state)
            S_FETCH: if (!w_stall) begin
                w_iwb_req = 1'b1;
                if (iwb_ack_i | iwb_err_i) w_state_nxt = S_EXEC;
            end
            S_EXEC:  w_state_nxt = w_is_mem ? S_MEM : S_FETCH;
            S_MEM: begin
                w_dwb_req = 1'b1;
                if (dwb_ack_i | dwb_err_i) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase
        if (rst_i) begin
            w_iwb_req = 1'b0;
            w_dwb_req = 1'b0;
        end
    end

    // ---------------- GPR write port ----------------
    logic        w_gpr_we;
    logic [4:0]  w_gpr_wa;
    logic [31:0] w_gpr_wd;
    always_comb begin
        w_gpr_we = 1'b0;
        w_gpr_wa = w_wr_rd;
        w_gpr_wd = w_wr_val;
        if (r_state == S_EXEC) begin
            w_gpr_we = w_wr_en;
        end else if (r_state == S_MEM && !r_we && (dwb_ack_i | dwb_err_i)) begin
            w_gpr_we = 1'b1;
            w_gpr_wa = r_ld_rd;
            w_gpr_wd = dwb_ack_i ? w_ld_val : 32'h0;
        end
        if (rst_i || w_gpr_wa == 5'd0) w_gpr_we = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (w_gpr_we) r_gpr[w_gpr_wa] <= w_gpr_wd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FETCH;  r_pc <= RESET_PC;  r_insn <= NOP_INSN;
            r_flag <= 1'b0;      r_in_slot <= 1'b0; r_target <= 32'h0;
            r_ea <= 32'h0;       r_wdata <= 32'h0;  r_sel <= 4'h0;
            r_we <= 1'b0;        r_ld_op <= 6'h0;   r_ld_rd <= 5'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_FETCH: if (w_iwb_req) begin
                    if (iwb_ack_i)      r_insn <= iwb_dat_i;
                    else if (iwb_err_i) r_insn <= NOP_INSN;
                end
                S_EXEC: begin
                    if (w_flag_en) r_flag <= w_flag_val;
                    if (r_in_slot) begin
                        r_pc      <= r_target;
                        r_in_slot <= 1'b0;
                    end else begin
                        r_pc <= r_pc + 32'd4;
                        if (w_taken) begin
                            r_in_slot <= 1'b1;
                            r_target  <= w_br_tgt;
                        end
                    end
                    r_ea    <= w_ea_al;
                    r_sel   <= w_mem_sel;
                    r_we    <= w_mem_we;
                    r_wdata <= w_mem_wdata;
                    r_ld_op <= w_op;
                    r_ld_rd <= w_rd;
                end
                default: ;
            endcase
        end
    end

    assign iwb_cyc_o = w_iwb_req;
    assign iwb_stb_o = w_iwb_req;
    assign iwb_adr_o = w_iwb_req ? r_pc : 32'h0;
    assign iwb_we_o  = 1'b0;
    assign iwb_sel_o = 4'hF;
    assign iwb_dat_o = 32'h0;
    assign iwb_cti_o = 3'h0;
    assign iwb_bte_o = 2'h0;

    assign dwb_cyc_o = w_dwb_req;
    assign dwb_stb_o = w_dwb_req;
    assign dwb_we_o  = w_dwb_req & r_we;
    assign dwb_adr_o = w_dwb_req ? r_ea : 32'h0;
    assign dwb_sel_o = w_dwb_req ? r_sel : 4'h0;
    assign dwb_dat_o = (w_dwb_req & r_we) ? r_wdata : 32'h0;
    assign dwb_cti_o = 3'h0;
    assign dwb_bte_o = 2'h0;

    assign dbg_lss_o = 4'h0;
    assign dbg_is_o  = 2'h0;
    assign dbg_wp_o  = 11'h0;
    assign dbg_bp_o  = 1'b0;
    assign dbg_dat_o = 32'h0;
    assign dbg_ack_o = dbg_stb_i;

    assign pm_clksd_o     = 4'h0;
    assign pm_dc_gate_o   = 1'b0;
    assign pm_ic_gate_o   = 1'b0;
    assign pm_dmmu_gate_o = 1'b0;
    assign pm_immu_gate_o = 1'b0;
    assign pm_tt_gate_o   = 1'b0;
    assign pm_cpu_gate_o  = 1'b0;
    assign pm_wakeup_o    = 1'b0;
    assign pm_lvolt_o     = 1'b0;
    assign sig_tick       = 1'b0;

    assign w_unused = ^{iwb_clk_i, iwb_rst_i, dwb_clk_i, dwb_rst_i, clmode_i, pic_ints_i,
                        iwb_rty_i, dwb_rty_i, dbg_ewt_i, dbg_we_i, dbg_adr_i, dbg_dat_i};
endmodule

// File: tb/tb_or1200_lite_top.sv
// tb/tb_or1200_lite_top.sv - self-checking bench for or1200_lite_top
module tb_or1200_lite_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pm_cpustall, dbg_stall, dbg_stb;
    logic        iwb_cyc, iwb_stb, iwb_we, dwb_cyc, dwb_stb, dwb_we, dbg_bp, dbg_ack;
    logic [3:0]  iwb_sel, dwb_sel, dbg_lss, pm_clksd;
    logic [31:0] iwb_adr, iwb_dato, dwb_adr, dwb_dato, dbg_dato, iwb_dati, dwb_dati;
    logic [2:0]  iwb_cti, dwb_cti;
    logic [1:0]  iwb_bte, dwb_bte, dbg_is;
    logic [10:0] dbg_wp;
    logic        pm_dc, pm_ic, pm_dmmu, pm_immu, pm_tt, pm_cpu, pm_wake, pm_lv, tick;

    logic [31:0] mem [0:16383];
    assign iwb_dati = mem[iwb_adr[15:2]];
    assign dwb_dati = mem[dwb_adr[15:2]];

    or1200_lite_top dut (
        .clk_i(clk), .rst_i(rst), .iwb_clk_i(clk), .iwb_rst_i(rst), .dwb_clk_i(clk),
        .dwb_rst_i(rst), .clmode_i(2'b00), .pic_ints_i(20'h0),
        .iwb_cyc_o(iwb_cyc), .iwb_stb_o(iwb_stb), .iwb_we_o(iwb_we), .iwb_sel_o(iwb_sel),
        .iwb_adr_o(iwb_adr), .iwb_dat_o(iwb_dato), .iwb_cti_o(iwb_cti), .iwb_bte_o(iwb_bte),
        .iwb_dat_i(iwb_dati), .iwb_ack_i(iwb_stb), .iwb_err_i(1'b0), .iwb_rty_i(1'b0),
        .dwb_cyc_o(dwb_cyc), .dwb_stb_o(dwb_stb), .dwb_we_o(dwb_we), .dwb_sel_o(dwb_sel),
        .dwb_adr_o(dwb_adr), .dwb_dat_o(dwb_dato), .dwb_cti_o(dwb_cti), .dwb_bte_o(dwb_bte),
        .dwb_dat_i(dwb_dati), .dwb_ack_i(dwb_stb), .dwb_err_i(1'b0), .dwb_rty_i(1'b0),
        .dbg_stall_i(dbg_stall), .dbg_ewt_i(1'b0), .dbg_stb_i(dbg_stb), .dbg_we_i(1'b0),
        .dbg_adr_i(32'h0), .dbg_dat_i(32'h0), .dbg_lss_o(dbg_lss), .dbg_is_o(dbg_is),
        .dbg_wp_o(dbg_wp), .dbg_bp_o(dbg_bp), .dbg_dat_o(dbg_dato), .dbg_ack_o(dbg_ack),
        .pm_cpustall_i(pm_cpustall), .pm_clksd_o(pm_clksd), .pm_dc_gate_o(pm_dc),
        .pm_ic_gate_o(pm_ic), .pm_dmmu_gate_o(pm_dmmu), .pm_immu_gate_o(pm_immu),
        .pm_tt_gate_o(pm_tt), .pm_cpu_gate_o(pm_cpu), .pm_wakeup_o(pm_wake),
        .pm_lvolt_o(pm_lv), .sig_tick(tick)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    endtask

    // Data bus write memory model
    always @(posedge clk) begin
        if (dwb_stb && dwb_we)
            for (int k = 0; k < 4; k++)
                if (dwb_sel[k]) mem[dwb_adr[15:2]][8*k +: 8] <= dwb_dato[8*k +: 8];
    end

    // Scoreboard of expected data writes
    typedef struct { logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; } wr_t;
    wr_t sb[$];
    logic [31:0] skip_a, skip_b, skip_c;
    int skip_hits = 0;

    always @(negedge clk) begin
        if (!rst && dwb_stb && dwb_we) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected_write actual=%08h required=none", dwb_adr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("sb_adr", dwb_adr, e.adr);
                check("sb_dat", dwb_dato, e.dat);
                check("sb_sel", {28'h0, dwb_sel}, {28'h0, e.sel});
            end
        end
        if (iwb_stb && (iwb_adr == skip_a || iwb_adr == skip_b || iwb_adr == skip_c))
            skip_hits++;
    end

    // Instruction encoders
    function automatic logic [31:0] e_ri(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [15:0] imm);
        return {op, rd, ra, imm};
    endfunction
    function automatic logic [31:0] e_rr(input logic [4:0] rd, input logic [4:0] ra,
                                         input logic [4:0] rb, input logic [1:0] st,
                                         input logic [3:0] fn);
        return {6'h38, rd, ra, rb, 3'b000, st, 2'b00, fn};
    endfunction
    function automatic logic [31:0] e_st(input logic [5:0] op, input logic [4:0] ra,
                                         input logic [4:0] rb, input logic [15:0] off);
        return {op, off[15:11], ra, rb, off[10:0]};
    endfunction
    function automatic logic [31:0] e_sf(input logic [4:0] c, input logic [4:0] ra,
                                         input logic [4:0] rb);
        return {6'h39, c, ra, rb, 11'h0};
    endfunction
    function automatic logic [31:0] e_br(input logic [5:0] op, input logic [25:0] n);
        return {op, n};
    endfunction
    function automatic logic [31:0] e_shi(input logic [1:0] st, input logic [4:0] amt);
        return {6'h2E, 5'd12, 5'd10, 8'h00, st, 1'b0, amt};
    endfunction

    int pc_w;
    task automatic emit(input logic [31:0] w);
        mem[pc_w] = w;
        pc_w++;
    endtask
    task automatic ld_const(input logic [4:0] rd, input logic [31:0] v);
        emit(e_ri(6'h06, rd, 5'd0, v[31:16]));
        emit(e_ri(6'h2A, rd, rd, v[15:0]));
    endtask
    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.adr = a; e.dat = d; e.sel = s;
        sb.push_back(e);
    endtask

    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] insn; bit is_sf; logic [31:0] exp; } vec_t;
    vec_t vt[$];
    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] insn, input bit is_sf, input logic [31:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.insn = insn; v.is_sf = is_sf; v.exp = exp;
        return v;
    endfunction

    logic [31:0] stall_x, q;
    bit found;

    initial begin
        rst = 1'b1; pm_cpustall = 1'b0; dbg_stall = 1'b0; dbg_stb = 1'b0;
        skip_a = 32'hFFFF_FFFF; skip_b = 32'hFFFF_FFFF; skip_c = 32'hFFFF_FFFF;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[32'h8100 >> 2] = 32'h80FF_0000;

        // ALU / compare vectors: rA=r10, rB=r11, result in r12
        vt.push_back(mk(32'hFFFF_FFFF, 32'h2,         e_rr(12,10,11,2'd0,4'h0), 0, 32'h0000_0001));
        vt.push_back(mk(32'h1,         32'h2,         e_rr(12,10,11,2'd0,4'h2), 0, 32'hFFFF_FFFF));
        vt.push_back(mk(32'hF0F0_1234, 32'h0FF0_FFFF, e_rr(12,10,11,2'd0,4'h3), 0, 32'h00F0_1234));
        vt.push_back(mk(32'hF000_0000, 32'h0000_000F, e_rr(12,10,11,2'd0,4'h4), 0, 32'hF000_000F));
        vt.push_back(mk(32'hAAAA_5555, 32'hFFFF_0000, e_rr(12,10,11,2'd0,4'h5), 0, 32'h5555_5555));
        vt.push_back(mk(32'h1,         32'd31,        e_rr(12,10,11,2'd0,4'h8), 0, 32'h8000_0000));
        vt.push_back(mk(32'h8000_0000, 32'd4,         e_rr(12,10,11,2'd1,4'h8), 0, 32'h0800_0000));
        vt.push_back(mk(32'h8000_0000, 32'd4,         e_rr(12,10,11,2'd2,4'h8), 0, 32'hF800_0000));
        vt.push_back(mk(32'h8000_0001, 32'd32,        e_rr(12,10,11,2'd2,4'h8), 0, 32'h8000_0001));
        vt.push_back(mk(32'hF000_0000, 32'h0,         e_shi(2'd2, 5'd28),       0, 32'hFFFF_FFFF));
        vt.push_back(mk(32'h5,         32'h0,         e_ri(6'h27,12,10,16'hFFFF), 0, 32'h0000_0004));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h0,         e_ri(6'h29,12,10,16'h8001), 0, 32'h0000_8001));
        vt.push_back(mk(32'h0,         32'h0,         e_ri(6'h2B,12,10,16'h8000), 0, 32'hFFFF_8000));
        vt.push_back(mk(32'h1234_0000, 32'h0,         e_ri(6'h2A,12,10,16'hFFFF), 0, 32'h1234_FFFF));
        vt.push_back(mk(32'h0,         32'h0,         e_ri(6'h06,12,0,16'hBEEF),  0, 32'hBEEF_0000));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h1,         e_sf(5'h02,10,11), 1, 32'h1));
        vt.push_back(mk(32'hFFFF_FFFF, 32'h1,         e_sf(5'h0A,10,11), 1, 32'h0));
        vt.push_back(mk(32'h8000_0000, 32'h0,         e_sf(5'h0D,10,11), 1, 32'h1));
        vt.push_back(mk(32'h5,         32'h5,         e_sf(5'h01,10,11), 1, 32'h0));
        vt.push_back(mk(32'h3,         32'h3,         e_sf(5'h03,10,11), 1, 32'h1));
        vt.push_back(mk(32'hFFFF_FFFE, 32'h0,         e_ri(6'h2F,5'h0C,10,16'hFFFF), 1, 32'h1));
        vt.push_back(mk(32'h4,         32'h3,         e_sf(5'h05,10,11), 1, 32'h0));

        // Program image at 0x100
        pc_w = 32'h100 >> 2;
        emit(e_ri(6'h06, 1, 0, 16'h0));
        emit(e_ri(6'h2A, 1, 1, 16'h8000));
        emit(e_ri(6'h27, 2, 0, 16'h1234));
        emit(e_st(6'h35, 1, 2, 16'h0));        expect_wr(32'h8000, 32'h0000_1234, 4'hF);
        emit(e_ri(6'h24, 3, 1, 16'h100));
        emit(e_ri(6'h25, 4, 1, 16'h100));
        emit(e_ri(6'h23, 5, 1, 16'h101));
        emit(e_ri(6'h26, 6, 1, 16'h100));
        emit(e_ri(6'h21, 7, 1, 16'h102));
        emit(e_ri(6'h21, 0, 1, 16'h100));
        emit(e_st(6'h35, 1, 3, 16'h104));      expect_wr(32'h8104, 32'hFFFF_FF80, 4'hF);
        emit(e_st(6'h35, 1, 4, 16'h108));      expect_wr(32'h8108, 32'h0000_80FF, 4'hF);
        emit(e_st(6'h35, 1, 5, 16'h10C));      expect_wr(32'h810C, 32'h0000_00FF, 4'hF);
        emit(e_st(6'h35, 1, 6, 16'h110));      expect_wr(32'h8110, 32'hFFFF_80FF, 4'hF);
        emit(e_st(6'h35, 1, 7, 16'h114));      expect_wr(32'h8114, 32'h80FF_0000, 4'hF);
        emit(e_st(6'h35, 1, 0, 16'h118));      expect_wr(32'h8118, 32'h0000_0000, 4'hF);
        emit(e_ri(6'h27, 2, 0, 16'h00AB));
        emit(e_st(6'h36, 1, 2, 16'h3));        expect_wr(32'h8003, 32'hABAB_ABAB, 4'h1);
        emit(e_st(6'h36, 1, 2, 16'h0));        expect_wr(32'h8000, 32'hABAB_ABAB, 4'h8);
        emit(e_st(6'h37, 1, 2, 16'h2));        expect_wr(32'h8002, 32'h00AB_00AB, 4'h3);
        emit(e_st(6'h37, 1, 2, 16'h1));        expect_wr(32'h8000, 32'h00AB_00AB, 4'hC);
        emit(e_st(6'h35, 1, 2, 16'h3));        expect_wr(32'h8000, 32'h0000_00AB, 4'hF);
        // Taken l.bf: delay slot runs, following instruction skipped
        emit(e_sf(5'h00, 0, 0));
        emit(e_br(6'h04, 26'd3));
        emit(e_ri(6'h27, 5, 0, 16'h1));
        skip_a = pc_w * 4;
        emit(e_ri(6'h27, 5, 0, 16'h2));
        emit(e_st(6'h35, 1, 5, 16'h10));       expect_wr(32'h8010, 32'h1, 4'hF);
        // l.jal links PC+8
        q = pc_w * 4;
        emit(e_br(6'h01, 26'd3));
        emit(32'h1500_0000);
        skip_b = pc_w * 4;
        emit(e_ri(6'h27, 9, 0, 16'h7));
        emit(e_st(6'h35, 1, 9, 16'h14));       expect_wr(32'h8014, q + 32'd8, 4'hF);
        // Branch in a delay slot behaves as a nop
        emit(e_br(6'h00, 26'd3));
        emit(e_br(6'h00, 26'd100));
        skip_c = pc_w * 4;
        emit(e_ri(6'h27, 5, 0, 16'h5));
        emit(e_st(6'h35, 1, 5, 16'h18));       expect_wr(32'h8018, 32'h1, 4'hF);
        // Vector table
        stall_x = pc_w * 4;
        for (int i = 0; i < vt.size(); i++) begin
            ld_const(10, vt[i].a);
            ld_const(11, vt[i].b);
            emit(vt[i].insn);
            if (vt[i].is_sf) begin
                emit(e_br(6'h03, 26'd3));
                emit(e_ri(6'h27, 12, 0, 16'h0));
                emit(e_ri(6'h27, 12, 0, 16'h1));
            end
            emit(e_st(6'h35, 1, 12, 16'h200 + 16'(4 * i)));
            expect_wr(32'h8200 + 32'(4 * i), vt[i].exp, 4'hF);
        end
        emit(e_br(6'h00, 26'd0));
        emit(32'h1500_0000);

        // Reset state and first fetches
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_iwb_cyc", {31'h0, iwb_cyc}, 32'h0);
        check("rst_dwb_cyc", {31'h0, dwb_cyc}, 32'h0);
        check("rst_iwb_adr", iwb_adr, 32'h0);
        dbg_stb = 1'b1; #1;
        check("dbg_ack", {31'h0, dbg_ack}, 32'h1);
        dbg_stb = 1'b0;
        rst = 1'b0; #1;
        check("fetch0_stb", {31'h0, iwb_stb}, 32'h1);
        check("fetch0_adr", iwb_adr, 32'h100);
        @(negedge clk);
        check("exec0_nostb", {31'h0, iwb_stb}, 32'h0);
        @(negedge clk);
        check("fetch1_adr", iwb_stb ? iwb_adr : 32'hDEAD_DEAD, 32'h104);
        repeat (2) @(negedge clk);
        check("fetch2_adr", iwb_stb ? iwb_adr : 32'hDEAD_DEAD, 32'h108);

        // Stall while fetch of the vector-table start is pending
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (iwb_stb && iwb_adr == stall_x) found = 1'b1;
        end
        check("stall_point_reached", {31'h0, found}, 32'h1);
        pm_cpustall = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("stall_no_fetch", {31'h0, iwb_stb}, 32'h0);
            @(negedge clk);
        end
        pm_cpustall = 1'b0; #1;
        check("resume_stb", {31'h0, iwb_stb}, 32'h1);
        check("resume_adr", iwb_adr, stall_x);

        for (int c = 0; c < 20000 && sb.size() != 0; c++) @(negedge clk);
        check("sb_drained", sb.size(), 32'h0);
        check("skipped_not_fetched", skip_hits, 32'h0);

        // Reset in the middle of a fetch cycle
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (iwb_stb) found = 1'b1;
        end
        check("midrst_fetch_seen", {31'h0, found}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_iwb_cyc", {31'h0, iwb_cyc}, 32'h0);
        check("midrst_dwb_cyc", {31'h0, dwb_cyc}, 32'h0);
        rst = 1'b0; #1;
        check("midrst_refetch_adr", iwb_adr, 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
